// File: rtl/ctrl_pkg.sv
// Shared types and encodings for the CA_P2 multi-cycle control unit:
// FSM states, decoded operation kinds, opcode field values and select codes.
package ctrl_pkg;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_FETCH,
    ST_DECODE,
    ST_EXEC,
    ST_MEM,
    ST_WB,
    ST_HALT,
    ST_ERROR
  } state_e;

  typedef enum logic [3:0] {
    OP_RALU,
    OP_IALU,
    OP_SHIFT,
    OP_LDM,
    OP_STM,
    OP_BRANCH,
    OP_JMP,
    OP_HALT,
    OP_ILLEGAL
  } op_e;

  localparam logic [1:0] CLS_RALU   = 2'b00;
  localparam logic [1:0] CLS_IALU   = 2'b01;

  localparam logic [2:0] SUB_MEM    = 3'b100;
  localparam logic [2:0] SUB_BRANCH = 3'b101;
  localparam logic [2:0] SUB_SHIFT  = 3'b110;
  localparam logic [2:0] SUB_CTRL   = 3'b111;

  localparam logic [1:0] FN2_LDM    = 2'b00;
  localparam logic [1:0] FN2_STM    = 2'b01;
  localparam logic [1:0] FN2_JMP    = 2'b00;
  localparam logic [1:0] FN2_HALT   = 2'b11;

  localparam logic [1:0] BR_Z       = 2'b00;
  localparam logic [1:0] BR_NZ      = 2'b01;
  localparam logic [1:0] BR_C       = 2'b10;
  localparam logic [1:0] BR_NC      = 2'b11;

  localparam logic [1:0] WSRC_ALU   = 2'b00;
  localparam logic [1:0] WSRC_IMM   = 2'b01;
  localparam logic [1:0] WSRC_SHIFT = 2'b10;
  localparam logic [1:0] WSRC_MEM   = 2'b11;

  localparam logic [1:0] ARG_REG    = 2'b00;
  localparam logic [1:0] ARG_IMM    = 2'b01;

  function automatic logic branchTaken(input logic [1:0] cond,
                                       input logic zeroFlag,
                                       input logic carryFlag);
    logic taken;
    case (cond)
      BR_Z:    taken = zeroFlag;
      BR_NZ:   taken = ~zeroFlag;
      BR_C:    taken = carryFlag;
      BR_NC:   taken = ~carryFlag;
      default: taken = 1'b0;
    endcase
    return taken;
  endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational opcode decoder: classifies the top five instruction bits,
// flags illegal encodings and resolves branch conditions against the flags.
module ctrl_decode
  import ctrl_pkg::*;
(
  input  logic [4:0] opField_i,
  input  logic       zero_flag_i,
  input  logic       carry_flag_i,
  output op_e        op_o,
  output logic       illegal_o,
  output logic       taken_o
);

  logic [1:0] cls;
  logic [2:0] sub;
  logic [1:0] fn2;

  assign cls = opField_i[4:3];
  assign sub = opField_i[4:2];
  assign fn2 = opField_i[1:0];

  always_comb begin
    op_o    = OP_ILLEGAL;
    taken_o = 1'b0;
    if (cls == CLS_RALU) begin
      op_o = OP_RALU;
    end else if (cls == CLS_IALU) begin
      op_o = OP_IALU;
    end else begin
      case (sub)
        SUB_SHIFT:  op_o = OP_SHIFT;
        SUB_MEM: begin
          if (fn2 == FN2_LDM)      op_o = OP_LDM;
          else if (fn2 == FN2_STM) op_o = OP_STM;
        end
        SUB_BRANCH: begin
          op_o    = OP_BRANCH;
          taken_o = branchTaken(fn2, zero_flag_i, carry_flag_i);
        end
        SUB_CTRL: begin
          if (fn2 == FN2_JMP)       op_o = OP_JMP;
          else if (fn2 == FN2_HALT) op_o = OP_HALT;
        end
        default: op_o = OP_ILLEGAL;
      endcase
    end
  end

  assign illegal_o = (op_o == OP_ILLEGAL);

endmodule

// File: rtl/multicycle_controller.sv
// Multi-cycle FSM sequencing fetch/decode/execute/memory/write-back for CA_P2.
// Define CTRL_TIMEOUT_EN to add a memory-wait watchdog that traps into ERROR.
module multicycle_controller
  import ctrl_pkg::*;
#(
  parameter int IW      = 19,
  parameter int TIMEOUT = 255
) (
  input  logic          clock,
  input  logic          rst,
  input  logic [IW-1:0] instr,
  input  logic          zero_flag,
  input  logic          carry_flag,
  input  logic          mem_ready,
  output logic          mem_req,
  output logic          mem_read,
  output logic          mem_write,
  output logic          sel_addr,
  output logic          ir_load,
  output logic          pc_en,
  output logic          pc_sel,
  output logic          rst_pc,
  output logic          rst_zero,
  output logic          rst_carry,
  output logic [2:0]    alu_fn,
  output logic [1:0]    sh_ro_fn,
  output logic [1:0]    sel_alu_arg,
  output logic          sel_r2,
  output logic [1:0]    sel_to_write,
  output logic          reg_write,
  output logic          zero_en,
  output logic          carry_en,
  output logic          illegal,
  output logic          halted,
  output logic          err
);

  state_e     state_q, state_d;
  op_e        opDec;
  logic       illegalDec;
  logic       takenDec;
  logic [2:0] fn3;
  logic [1:0] fn2;
  logic       unusedInstr;

  assign fn3         = instr[IW-3:IW-5];
  assign fn2         = instr[IW-4:IW-5];
  assign unusedInstr = ^instr[IW-6:0];

  ctrl_decode u_decode (
    .opField_i    (instr[IW-1:IW-5]),
    .zero_flag_i  (zero_flag),
    .carry_flag_i (carry_flag),
    .op_o         (opDec),
    .illegal_o    (illegalDec),
    .taken_o      (takenDec)
  );

`ifdef CTRL_TIMEOUT_EN
  localparam int TW = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;

  logic [TW-1:0] waitCnt_q, waitCnt_d;
  logic          timeoutHit;

  // Counts consecutive unanswered memory cycles; any other state or a ready clears it.
  always_comb begin
    waitCnt_d  = '0;
    timeoutHit = 1'b0;
    if ((state_q == ST_FETCH || state_q == ST_MEM) && !mem_ready) begin
      waitCnt_d  = waitCnt_q + TW'(1);
      timeoutHit = (waitCnt_d == TW'(TIMEOUT));
    end
  end

  always_ff @(posedge clock) begin
    if (rst) waitCnt_q <= '0;
    else     waitCnt_q <= waitCnt_d;
  end
`else
  localparam int unusedTimeout = TIMEOUT;
`endif

  always_ff @(posedge clock) begin
    if (rst) state_q <= ST_INIT;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d      = state_q;
    mem_req      = 1'b0;
    mem_read     = 1'b0;
    mem_write    = 1'b0;
    sel_addr     = 1'b0;
    ir_load      = 1'b0;
    pc_en        = 1'b0;
    pc_sel       = 1'b0;
    rst_pc       = 1'b0;
    rst_zero     = 1'b0;
    rst_carry    = 1'b0;
    alu_fn       = 3'b000;
    sh_ro_fn     = 2'b00;
    sel_alu_arg  = ARG_REG;
    sel_r2       = 1'b0;
    sel_to_write = WSRC_ALU;
    reg_write    = 1'b0;
    zero_en      = 1'b0;
    carry_en     = 1'b0;
    illegal      = 1'b0;
    halted       = 1'b0;
    err          = 1'b0;

    case (state_q)
      ST_INIT: begin
        rst_pc    = 1'b1;
        rst_zero  = 1'b1;
        rst_carry = 1'b1;
        state_d   = ST_FETCH;
      end

      ST_FETCH: begin
        mem_req  = 1'b1;
        mem_read = 1'b1;
        if (mem_ready) begin
          ir_load = 1'b1;
          pc_en   = 1'b1;
          state_d = ST_DECODE;
        end
`ifdef CTRL_TIMEOUT_EN
        else if (timeoutHit) state_d = ST_ERROR;
`endif
      end

      // Branches and jumps retire here; their target is written through pc_sel.
      ST_DECODE: begin
        state_d = ST_FETCH;
        case (opDec)
          OP_RALU, OP_IALU, OP_SHIFT: state_d = ST_EXEC;
          OP_LDM, OP_STM:             state_d = ST_MEM;
          OP_BRANCH: begin
            pc_sel = 1'b1;
            pc_en  = takenDec;
          end
          OP_JMP: begin
            pc_sel = 1'b1;
            pc_en  = 1'b1;
          end
          OP_HALT: state_d = ST_HALT;
          default: illegal = illegalDec;
        endcase
      end

      ST_EXEC: begin
        reg_write = 1'b1;
        zero_en   = 1'b1;
        alu_fn    = fn3;
        sh_ro_fn  = fn2;
        state_d   = ST_FETCH;
        case (opDec)
          OP_RALU: begin
            sel_to_write = WSRC_ALU;
            carry_en     = 1'b1;
          end
          OP_IALU: begin
            sel_to_write = WSRC_IMM;
            sel_alu_arg  = ARG_IMM;
            carry_en     = 1'b1;
          end
          OP_SHIFT: sel_to_write = WSRC_SHIFT;
          default:  sel_to_write = WSRC_ALU;
        endcase
      end

      ST_MEM: begin
        mem_req  = 1'b1;
        sel_addr = 1'b1;
        if (opDec == OP_LDM) begin
          mem_read = 1'b1;
        end else begin
          mem_write = 1'b1;
          sel_r2    = 1'b1;
        end
        if (mem_ready) begin
          state_d = (opDec == OP_LDM) ? ST_WB : ST_FETCH;
        end
`ifdef CTRL_TIMEOUT_EN
        else if (timeoutHit) state_d = ST_ERROR;
`endif
      end

      ST_WB: begin
        reg_write    = 1'b1;
        sel_to_write = WSRC_MEM;
        state_d      = ST_FETCH;
      end

      ST_HALT: halted = 1'b1;

      ST_ERROR: begin
`ifdef CTRL_TIMEOUT_EN
        err = 1'b1;
`endif
      end

      default: state_d = ST_INIT;
    endcase
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller: table-driven cycle counts,
// hand sequences for waits/halt/reset, and random traces from a phase-level model.
module tb_multicycle_controller;

  localparam int IW = 19;
  localparam int TO = 4;
`ifdef CTRL_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic          clock;
  logic          rst;
  logic [IW-1:0] instr;
  logic          zero_flag, carry_flag, mem_ready;
  logic          mem_req, mem_read, mem_write, sel_addr, ir_load, pc_en, pc_sel;
  logic          rst_pc, rst_zero, rst_carry;
  logic [2:0]    alu_fn;
  logic [1:0]    sh_ro_fn, sel_alu_arg, sel_to_write;
  logic          sel_r2, reg_write, zero_en, carry_en, illegal, halted, err;

  multicycle_controller #(.IW(IW), .TIMEOUT(TO)) dut (
    .clock(clock), .rst(rst), .instr(instr),
    .zero_flag(zero_flag), .carry_flag(carry_flag), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_read(mem_read), .mem_write(mem_write),
    .sel_addr(sel_addr), .ir_load(ir_load), .pc_en(pc_en), .pc_sel(pc_sel),
    .rst_pc(rst_pc), .rst_zero(rst_zero), .rst_carry(rst_carry),
    .alu_fn(alu_fn), .sh_ro_fn(sh_ro_fn), .sel_alu_arg(sel_alu_arg),
    .sel_r2(sel_r2), .sel_to_write(sel_to_write), .reg_write(reg_write),
    .zero_en(zero_en), .carry_en(carry_en), .illegal(illegal),
    .halted(halted), .err(err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct packed {
    logic memReq, memRead, memWrite, selAddr, irLoad, pcEn, pcSel;
    logic rstPc, rstZero, rstCarry;
    logic [2:0] aluFn;
    logic [1:0] shFn;
    logic [1:0] aluArg;
    logic       selR2;
    logic [1:0] wSrc;
    logic regWrite, zeroEn, carryEn, illegal, halted, err;
  } outVec_t;

  typedef enum {K_RALU, K_IALU, K_SHIFT, K_LDM, K_STM, K_BRANCH, K_JMP, K_HALT, K_ILL} kind_e;

  typedef struct {
    logic   ready;
    outVec_t exp;
  } cyc_t;

  typedef struct {
    logic [4:0] top;
    logic       z;
    logic       c;
    int         expCycles;
    logic       expTaken;
  } vec_t;

  int   checks;
  int   failures;
  cyc_t trace[$];

  function automatic outVec_t sampleDut();
    outVec_t a;
    a = '{mem_req, mem_read, mem_write, sel_addr, ir_load, pc_en, pc_sel,
          rst_pc, rst_zero, rst_carry, alu_fn, sh_ro_fn, sel_alu_arg, sel_r2,
          sel_to_write, reg_write, zero_en, carry_en, illegal, halted, err};
    return a;
  endfunction

  function automatic outVec_t vInit();
    outVec_t v = '0;
    v.rstPc = 1'b1; v.rstZero = 1'b1; v.rstCarry = 1'b1;
    return v;
  endfunction

  function automatic outVec_t vFetch(input logic rdy);
    outVec_t v = '0;
    v.memReq = 1'b1; v.memRead = 1'b1;
    v.irLoad = rdy;  v.pcEn = rdy;
    return v;
  endfunction

  function automatic outVec_t vHalt();
    outVec_t v = '0;
    v.halted = 1'b1;
    return v;
  endfunction

  function automatic outVec_t vErr();
    outVec_t v = '0;
    v.err = 1'b1;
    return v;
  endfunction

  // Instruction classes straight from the opcode table.
  function automatic kind_e classify(input logic [4:0] top);
    if (top[4:3] == 2'b00) return K_RALU;
    if (top[4:3] == 2'b01) return K_IALU;
    if (top[4:2] == 3'b110) return K_SHIFT;
    if (top[4:2] == 3'b100) return (top[1:0] == 2'b00) ? K_LDM :
                                   (top[1:0] == 2'b01) ? K_STM : K_ILL;
    if (top[4:2] == 3'b101) return K_BRANCH;
    return (top[1:0] == 2'b00) ? K_JMP : (top[1:0] == 2'b11) ? K_HALT : K_ILL;
  endfunction

  function automatic logic condMet(input logic [1:0] cond, input logic z, input logic c);
    logic [3:0] table4;
    table4 = {~c, c, ~z, z};
    return table4[cond];
  endfunction

  task automatic checkOutput(input string name, input outVec_t exp);
    outVec_t act;
    act = sampleDut();
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: outputs got %h required %h", name, act, exp);
    end
  endtask

  task automatic checkValue(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0d required %0d", name, act, exp);
    end
  endtask

  // Expected per-cycle behaviour built phase by phase: fetch, decode, then execute/memory/write-back.
  task automatic buildTrace(input logic [IW-1:0] ins, input int fw, input int mw,
                            input logic z, input logic c);
    cyc_t  r;
    kind_e k;
    logic [4:0] top;
    top = ins[IW-1:IW-5];
    k   = classify(top);
    trace.delete();
    for (int i = 0; i < fw; i++) begin
      r.ready = 1'b0; r.exp = vFetch(1'b0); trace.push_back(r);
    end
    r.ready = 1'b1; r.exp = vFetch(1'b1); trace.push_back(r);
    r.ready = 1'($urandom_range(0, 1));
    r.exp   = '0;
    if (k == K_BRANCH) begin
      r.exp.pcSel = 1'b1; r.exp.pcEn = condMet(top[1:0], z, c);
    end else if (k == K_JMP) begin
      r.exp.pcSel = 1'b1; r.exp.pcEn = 1'b1;
    end else if (k == K_ILL) begin
      r.exp.illegal = 1'b1;
    end
    trace.push_back(r);
    if (k == K_RALU || k == K_IALU || k == K_SHIFT) begin
      r.ready = 1'($urandom_range(0, 1));
      r.exp = '0;
      r.exp.regWrite = 1'b1; r.exp.zeroEn = 1'b1;
      r.exp.aluFn = top[2:0]; r.exp.shFn = top[1:0];
      r.exp.carryEn = (k != K_SHIFT);
      r.exp.wSrc   = (k == K_RALU) ? 2'b00 : (k == K_IALU) ? 2'b01 : 2'b10;
      r.exp.aluArg = (k == K_IALU) ? 2'b01 : 2'b00;
      trace.push_back(r);
    end
    if (k == K_LDM || k == K_STM) begin
      for (int i = 0; i <= mw; i++) begin
        r.ready = (i == mw);
        r.exp = '0;
        r.exp.memReq = 1'b1; r.exp.selAddr = 1'b1;
        r.exp.memRead  = (k == K_LDM);
        r.exp.memWrite = (k == K_STM);
        r.exp.selR2    = (k == K_STM);
        trace.push_back(r);
      end
    end
    if (k == K_LDM) begin
      r.ready = 1'($urandom_range(0, 1));
      r.exp = '0; r.exp.regWrite = 1'b1; r.exp.wSrc = 2'b11;
      trace.push_back(r);
    end
  endtask

  task automatic applyStimulus(input string name, input logic [IW-1:0] ins, input int fw,
                               input int mw, input logic z, input logic c);
    buildTrace(ins, fw, mw, z, c);
    instr = ins; zero_flag = z; carry_flag = c;
    for (int i = 0; i < trace.size(); i++) begin
      mem_ready = trace[i].ready;
      #1;
      checkOutput($sformatf("%s cyc%0d", name, i), trace[i].exp);
      @(negedge clock);
    end
  endtask

  // Runs one instruction with zero-wait memory and measures cycles until the next fetch.
  task automatic measureInstr(input int idx, input vec_t v);
    int   cnt;
    logic found, pcEnDec;
    instr = {v.top, 14'($urandom)};
    zero_flag = v.z; carry_flag = v.c; mem_ready = 1'b1;
    cnt = 0; found = 1'b0; pcEnDec = 1'b0;
    for (int k = 0; k < 20; k++) begin
      #1;
      if (k == 0) checkValue($sformatf("vec%0d ir_load", idx), int'(ir_load), 1);
      if (k > 0 && mem_req && !sel_addr) begin
        found = 1'b1; cnt = k;
        break;
      end
      if (k == 1) pcEnDec = pc_en;
      @(negedge clock);
    end
    checkValue($sformatf("vec%0d next fetch reached", idx), int'(found), 1);
    checkValue($sformatf("vec%0d cycles", idx), cnt, v.expCycles);
    checkValue($sformatf("vec%0d decode pc_en", idx), int'(pcEnDec), int'(v.expTaken));
  endtask

  initial begin
    vec_t vecs[13];
    checks = 0; failures = 0;
    rst = 1'b1; instr = '0; zero_flag = 1'b0; carry_flag = 1'b0; mem_ready = 1'b0;

    vecs[0]  = '{5'b00000, 1'b0, 1'b0, 3, 1'b0};
    vecs[1]  = '{5'b01101, 1'b1, 1'b0, 3, 1'b0};
    vecs[2]  = '{5'b11010, 1'b0, 1'b1, 3, 1'b0};
    vecs[3]  = '{5'b10000, 1'b0, 1'b0, 4, 1'b0};
    vecs[4]  = '{5'b10001, 1'b0, 1'b0, 3, 1'b0};
    vecs[5]  = '{5'b10010, 1'b0, 1'b0, 2, 1'b0};
    vecs[6]  = '{5'b10100, 1'b1, 1'b0, 2, 1'b1};
    vecs[7]  = '{5'b10100, 1'b0, 1'b1, 2, 1'b0};
    vecs[8]  = '{5'b10101, 1'b0, 1'b0, 2, 1'b1};
    vecs[9]  = '{5'b10110, 1'b0, 1'b1, 2, 1'b1};
    vecs[10] = '{5'b10111, 1'b1, 1'b1, 2, 1'b0};
    vecs[11] = '{5'b11100, 1'b0, 1'b0, 2, 1'b1};
    vecs[12] = '{5'b11101, 1'b1, 1'b1, 2, 1'b0};

    @(negedge clock);
    #1 checkOutput("reset INIT", vInit());
    @(negedge clock);
    rst = 1'b0;
    #1 checkOutput("INIT after rst falls", vInit());
    @(negedge clock);
    #1 checkOutput("first fetch", vFetch(1'b0));

    for (int i = 0; i < 13; i++) measureInstr(i, vecs[i]);

    applyStimulus("alu add", {5'b00000, 14'h1234}, 0, 0, 1'b0, 1'b0);
    applyStimulus("ldm wait3", {5'b10000, 14'h0042}, 0, 3, 1'b0, 1'b0);
    applyStimulus("stm waits", {5'b10001, 14'h0101}, 2, 1, 1'b1, 1'b0);
    applyStimulus("bz taken", {5'b10100, 14'h0007}, 1, 0, 1'b1, 1'b0);
    applyStimulus("bz not taken", {5'b10100, 14'h0007}, 0, 0, 1'b0, 1'b1);

    for (int n = 0; n < 40; n++) begin
      logic [4:0] top;
      top = 5'($urandom_range(0, 31));
      if (top == 5'b11111) top = 5'b11110;
      applyStimulus($sformatf("rand%0d op%b", n, top), {top, 14'($urandom)},
                    $urandom_range(0, 3), $urandom_range(0, 3),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    applyStimulus("mem fn2=10", {5'b10010, 14'h0000}, 0, 0, 1'b0, 1'b0);

    instr = {5'b11111, 14'h0000}; mem_ready = 1'b1;
    #1 checkOutput("halt fetch", vFetch(1'b1));
    @(negedge clock);
    mem_ready = 1'($urandom_range(0, 1));
    #1 checkOutput("halt decode", '0);
    @(negedge clock);
    for (int i = 0; i < 20; i++) begin
      mem_ready = 1'($urandom_range(0, 1));
      #1 checkOutput($sformatf("halted cyc%0d", i), vHalt());
      @(negedge clock);
    end

    rst = 1'b1;
    @(negedge clock);
    rst = 1'b0;
    #1 checkOutput("reset from HALT", vInit());
    @(negedge clock);
    mem_ready = 1'b0;
    #1 checkOutput("fetch after halt reset", vFetch(1'b0));

    instr = {5'b10000, 14'h0003}; mem_ready = 1'b1;
    @(negedge clock);
    @(negedge clock);
    mem_ready = 1'b0;
    #1 checkValue("abort mem_req before rst", int'(mem_req & sel_addr & mem_read), 1);
    rst = 1'b1;
    @(negedge clock);
    rst = 1'b0;
    #1 checkOutput("abort mid-MEM", vInit());
    @(negedge clock);

    mem_ready = 1'b0;
    for (int k = 0; k < 6; k++) begin
      #1 checkOutput($sformatf("watchdog cyc%0d", k),
                     (TO_EN && k >= TO) ? vErr() : vFetch(1'b0));
      @(negedge clock);
    end
    rst = 1'b1;
    @(negedge clock);
    rst = 1'b0;
    #1 checkOutput("rst clears err", vInit());
    @(negedge clock);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Parametrised multi-cycle control unit for the CA_P2 processor datapath. It decodes the latched instruction into datapath selects, ALU/shift function codes, register-write and flag enables. It sequences fetch/decode/execute/memory/write-back through an explicit FSM. Memory accesses use a req/ready handshake with wait states, and the unit resolves conditional branches on the zero/carry flags.

## Interface
- IW, 19: instruction width; opcode fields are at the top: class = instr[IW-1:IW-2], sub = instr[IW-1:IW-3], fn3 = instr[IW-3:IW-5], fn2 = instr[IW-4:IW-5]
- TIMEOUT, 255: memory-wait watchdog limit in cycles (≥1; used only with CTRL_TIMEOUT_EN)
- clock  in  1  single clock; all state changes on posedge
- rst  in  1  synchronous, active-high reset
- instr  in  IW  instruction register contents (valid from the cycle after ir_load)
- zero_flag, carry_flag  in  1  current datapath flags
- mem_ready  in  1  memory completed the current request this cycle
- mem_req, mem_read, mem_write  out  1  memory request, direction
- sel_addr  out  1  0 = PC address, 1 = ALU/data address
- ir_load, pc_en  out  1  instruction-register load, PC write
- pc_sel  out  1  0 = PC+1, 1 = branch target
- rst_pc, rst_zero, rst_carry  out  1  datapath register clears
- alu_fn  out  3  ALU function (= fn3)
- sh_ro_fn  out  2  shift/rotate function (= fn2)
- sel_alu_arg  out  2  ALU B operand: 00 register, 01 immediate
- sel_r2  out  1  0 = R2 address from [7:5], 1 = from [13:11]
- sel_to_write  out  2  write-back source: 00 ALU, 01 immediate-ALU, 10 shifter, 11 memory
- reg_write, zero_en, carry_en  out  1  register-file write, flag updates
- illegal, halted, err  out  1  illegal-opcode pulse, halt level, watchdog error level

## Operation
- Decode: class 00 = R-ALU; 01 = I-ALU; sub 110 = shift/rotate; 100 = memory (fn2 00 LDM, 01 STM, else illegal); 101 = branch (fn2 00 BZ, 01 BNZ, 10 BC, 11 BNC); 111 = control (fn2 00 JMP, 11 HALT, else illegal).
- States: INIT, FETCH, DECODE, EXEC, MEM, WB, HALT, ERROR.
- INIT: rst_pc, rst_zero, rst_carry = 1 → FETCH.
- FETCH: mem_req = mem_read = 1, sel_addr = 0. When mem_ready: ir_load = 1, pc_en = 1, pc_sel = 0 → DECODE.
- DECODE:
  - ALU/shift → EXEC.
  - Memory → MEM.
  - Branch/JMP: pc_en = 1 only if taken (JMP always taken), pc_sel = 1 → FETCH.
  - HALT → HALT.
  - Illegal: illegal = 1 for one cycle → FETCH.
- EXEC: reg_write = 1 with sel_to_write per class.
  - ALU: zero_en = carry_en = 1.
  - Shift: zero_en = 1, carry_en = 0.
  - → FETCH.
- MEM: mem_req = 1, sel_addr = 1. LDM: mem_read = 1. STM: mem_write = 1, sel_r2 = 1. When mem_ready: STM → FETCH, LDM → WB.
- WB: reg_write = 1, sel_to_write = 11 → FETCH.
- HALT: halted = 1, no outputs active; exits only via rst.
- All control outputs are decoded combinationally from state and instr. Any output not stated for a state is 0.

## Timing
- rst high at a posedge → INIT next cycle. rst held high keeps the FSM in INIT. Leaving INIT takes one cycle after rst falls.
- rst mid-operation aborts immediately; any in-flight mem_req drops in the next cycle.
- Cycle counts with zero-wait memory:
  - ALU/shift: 3 (FETCH, DECODE, EXEC).
  - Branch/JMP/illegal: 2.
  - STM: 3.
  - LDM: 4.
- Each cycle with mem_ready = 0 adds one cycle. mem_req stays asserted until mem_ready is sampled high.
- mem_ready outside FETCH/MEM is ignored.
- Branch condition uses flags sampled in DECODE. A flag update in EXEC of the preceding instruction is therefore visible.
- Reset values: state = INIT, which drives rst_* = 1; every other output is 0.

## Configuration
- CTRL_TIMEOUT_EN defined:
  - An 8-bit-min counter ($clog2(TIMEOUT+1)) increments on each FETCH/MEM cycle with mem_ready = 0. It clears on entering those states and on mem_ready.
  - Reaching TIMEOUT → ERROR. In ERROR, err = 1 and all memory/enable outputs are 0, until rst.
- Undefined: no counter; waits are unbounded; err tied 0; ERROR unreachable.

## Structure
- ctrl_pkg holds:
  - the state enum;
  - class/sub/fn2 encoding constants;
  - sel_to_write and sel_alu_arg codes;
  - branch condition codes.
- One sub-module, ctrl_decode: combinational instr → class, legality and branch-taken from the flags. The FSM and output logic live in multicycle_controller.

## Test plan
- Reset: rst high 2 cycles, then low. Required: rst_pc = rst_zero = rst_carry = 1 during INIT, mem_req = 1 on the next cycle.
- ALU add with fn3 = 000, class 00, mem_ready tied 1. Required: ir_load at cycle 1; reg_write, zero_en, carry_en, sel_to_write = 00 exactly one cycle at cycle 3.
- LDM with mem_ready delayed 3 cycles in MEM. Required: mem_req and mem_read held 4 cycles with sel_addr = 1, then WB with sel_to_write = 11 for 1 cycle.
- BZ with zero_flag = 1, then with zero_flag = 0. Required: pc_en & pc_sel = 1 in DECODE for the first; no pc_en in DECODE for the second.
- Memory fn2 = 10 (illegal). Required: illegal pulses 1 cycle, FSM back in FETCH. Then HALT: halted = 1 steady for 20 cycles, mem_req = 0.
- With CTRL_TIMEOUT_EN and TIMEOUT = 4, mem_ready held 0 in FETCH. Required: err = 1 after exactly 4 wait cycles; rst clears it.
